// File: rtl/imem_loader_pkg.sv
// Shared types and helpers for the instruction-memory boot loader.
package imem_loader_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } state_t;

    function automatic int bytes_per_word(input int width);
        return width / 8;
    endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte packer: assembles one word from a stream of bytes.
// word_next already includes the byte being loaded this cycle.
module byte_packer
    import imem_loader_pkg::*;
#(
    parameter int RAM_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 load,
    input  logic [7:0]           byte_data,
    output logic [RAM_WIDTH-1:0] word_next,
    output logic                 last
);

    localparam int BYTES = bytes_per_word(RAM_WIDTH);
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    logic [IDX_W-1:0] byte_idx_reg;
    logic [IDX_W-1:0] byte_idx_next;

    assign last = (byte_idx_reg == IDX_W'(BYTES - 1));

    always_comb begin
        byte_idx_next = byte_idx_reg;
        if (clear) begin
            byte_idx_next = '0;
        end else if (load) begin
            byte_idx_next = last ? '0 : byte_idx_reg + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx_reg <= '0;
        end else begin
            byte_idx_reg <= byte_idx_next;
        end
    end

    // One register per byte lane; a lane loads only when byte_idx points at it.
    for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
        logic [7:0] lane_reg;
        logic       lane_hit;

        assign lane_hit = load && (byte_idx_reg == IDX_W'(gi));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                lane_reg <= '0;
            end else if (lane_hit) begin
                lane_reg <= byte_data;
            end
        end

        assign word_next[8*gi +: 8] = lane_hit ? byte_data : lane_reg;
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: byte stream in, word writes out,
// holding the CPU for the duration of the load.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int RAM_WIDTH     = 32,
    parameter int RAM_ADDR_BITS = 11
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [RAM_ADDR_BITS:0]   len,
    input  logic                     in_valid,
    input  logic [7:0]               in_data,
    output logic                     in_ready,
    output logic                     mem_w_en,
    output logic [RAM_ADDR_BITS-1:0] mem_addr,
    output logic [RAM_WIDTH-1:0]     mem_data,
    output logic                     cpu_hold,
    output logic                     done
);

    localparam logic [RAM_ADDR_BITS:0] MAX_LEN = {1'b1, {RAM_ADDR_BITS{1'b0}}};

    state_t state_reg;
    state_t state_next;

    logic [RAM_ADDR_BITS:0]   len_q_reg;
    logic [RAM_ADDR_BITS:0]   word_idx_reg;
    logic [RAM_ADDR_BITS:0]   word_idx_inc;
    logic [RAM_ADDR_BITS:0]   len_sat;
    logic [RAM_ADDR_BITS-1:0] mem_addr_reg;
    logic [RAM_WIDTH-1:0]     mem_data_reg;
    logic [RAM_WIDTH-1:0]     packer_word;
    logic                     packer_last;
    logic                     start_ok;
    logic                     accept;
    logic                     word_complete;

    assign start_ok      = (state_reg == IDLE) && start;
    assign accept        = (state_reg == COLLECT) && in_valid;
    assign word_complete = accept && packer_last;
    assign len_sat       = (len > MAX_LEN) ? MAX_LEN : len;
    assign word_idx_inc  = word_idx_reg + 1'b1;

    byte_packer #(
        .RAM_WIDTH (RAM_WIDTH)
    ) u_byte_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (start_ok),
        .load      (accept),
        .byte_data (in_data),
        .word_next (packer_word),
        .last      (packer_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = (len_sat == '0) ? DONE : COLLECT;
                end
            end
            COLLECT: begin
                if (word_complete) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                state_next = (word_idx_inc == len_q_reg) ? DONE : COLLECT;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        mem_w_en = 1'b0;
        cpu_hold = 1'b0;
        done     = 1'b0;
        case (state_reg)
            COLLECT: begin
                in_ready = 1'b1;
                cpu_hold = 1'b1;
            end
            WRITE: begin
                mem_w_en = 1'b1;
                cpu_hold = 1'b1;
            end
            DONE: begin
                cpu_hold = 1'b1;
                done     = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Address and data are captured with the last byte so they are stable
    // for the whole WRITE cycle and hold afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q_reg    <= '0;
            word_idx_reg <= '0;
            mem_addr_reg <= '0;
            mem_data_reg <= '0;
        end else begin
            if (start_ok) begin
                len_q_reg    <= len_sat;
                word_idx_reg <= '0;
            end else if (state_reg == WRITE) begin
                word_idx_reg <= word_idx_inc;
            end
            if (word_complete) begin
                mem_addr_reg <= word_idx_reg[RAM_ADDR_BITS-1:0];
                mem_data_reg <= packer_word;
            end
        end
    end

    assign mem_addr = mem_addr_reg;
    assign mem_data = mem_data_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes queued as words are sent,
// compared against writes observed on the memory port.
module tb_imem_loader;

    localparam int W  = 32;
    localparam int AW = 11;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW:0]   len;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          mem_w_en;
    logic [AW-1:0] mem_addr;
    logic [W-1:0]  mem_data;
    logic          cpu_hold;
    logic          done;

    always #5 clk = ~clk;

    imem_loader #(
        .RAM_WIDTH     (W),
        .RAM_ADDR_BITS (AW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .len      (len),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .mem_w_en (mem_w_en),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .cpu_hold (cpu_hold),
        .done     (done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Monitor-owned observations (written only by the negedge monitor)
    int            cyc            = 0;
    int            writes_total   = 0;
    int            done_total     = 0;
    int            hold_total     = 0;
    int            ready_total    = 0;
    int            double_we      = 0;
    int            last_write_cyc = -10;
    int            done_cyc       = -10;
    int            start_cyc      = -10;
    logic          prev_we        = 1'b0;
    logic [AW-1:0] obs_addr[$];
    logic [W-1:0]  obs_data[$];
    logic [W-1:0]  mem_model [0:(1<<AW)-1];

    // Main-process-owned scoreboard
    int            obs_rd = 0;
    logic [AW-1:0] exp_addr[$];
    logic [W-1:0]  exp_data[$];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (start) start_cyc <= cyc;
        if (mem_w_en) begin
            writes_total   <= writes_total + 1;
            last_write_cyc <= cyc;
            obs_addr.push_back(mem_addr);
            obs_data.push_back(mem_data);
            mem_model[mem_addr] <= mem_data;
            if (prev_we) double_we <= double_we + 1;
            $display("write addr=%0d data=%08h", mem_addr, mem_data);
        end
        prev_we <= mem_w_en;
        if (done) begin
            done_total <= done_total + 1;
            done_cyc   <= cyc;
            $display("done pulse at cycle %0d", cyc);
        end
        if (cpu_hold) hold_total  <= hold_total + 1;
        if (in_ready) ready_total <= ready_total + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int l);
        start = 1'b1;
        len   = (AW+1)'(l);
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int maxgap);
        int g;
        g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
        repeat (g) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            tick();
        end
        in_valid = 1'b1;
        in_data  = b;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                return;
            end
        end
        check("byte_accept_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [AW-1:0] a, input logic [W-1:0] w, input int maxgap);
        for (int b = 0; b < W/8; b++) begin
            send_byte(w[8*b +: 8], maxgap);
        end
        exp_addr.push_back(a);
        exp_data.push_back(w);
    endtask

    task automatic wait_done(input string tag);
        int d0;
        d0 = done_total;
        for (int t = 0; t < 20000; t++) begin
            tick();
            if (done_total > d0) return;
        end
        check({tag, "_done_timeout"}, 0, 1);
    endtask

    task automatic drain(input string tag);
        while (obs_rd < obs_addr.size()) begin
            if (exp_addr.size() == 0) begin
                check({tag, "_unexpected_write"}, 1, 0);
            end else begin
                check({tag, "_addr"}, obs_addr[obs_rd], exp_addr.pop_front());
                check({tag, "_data"}, obs_data[obs_rd], exp_data.pop_front());
            end
            obs_rd++;
        end
        check({tag, "_pending"}, exp_addr.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_mem_w_en"}, mem_w_en, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_mem_data"}, mem_data, 0);
        check({tag, "_cpu_hold"}, cpu_hold, 0);
        check({tag, "_done"},     done, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, h0, r0, d0;
        logic [W-1:0] t3 [3];
        t3[0] = 32'hCAFEF00D;
        t3[1] = 32'h0BADC0DE;
        t3[2] = 32'h8BADF00D;

        rst_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // Basic two-word load with in_valid held high
        w0 = writes_total;
        do_start(2);
        send_word(0, 32'h12345678, 0);
        send_word(1, 32'hDEADBEEF, 0);
        wait_done("t1");
        drain("t1");
        check("t1_write_count", writes_total - w0, 2);
        check("t1_done_latency", done_cyc, last_write_cyc + 1);
        check("t1_single_we", double_we, 0);

        // Zero-length load
        tick();
        w0 = writes_total; h0 = hold_total; r0 = ready_total; d0 = done_total;
        do_start(0);
        wait_done("t2");
        tick();
        check("t2_write_count", writes_total - w0, 0);
        check("t2_ready_cycles", ready_total - r0, 0);
        check("t2_hold_cycles", hold_total - h0, 1);
        check("t2_done_count", done_total - d0, 1);
        check("t2_done_latency", done_cyc, start_cyc + 1);

        // Random in_valid gaps
        w0 = writes_total;
        do_start(3);
        for (int i = 0; i < 3; i++) send_word(AW'(i), t3[i], 3);
        wait_done("t3");
        drain("t3");
        check("t3_write_count", writes_total - w0, 3);
        for (int i = 0; i < 3; i++) check("t3_mem", mem_model[i], t3[i]);

        // start pulsed mid-load must be ignored
        w0 = writes_total; d0 = done_total;
        do_start(4);
        send_word(0, 32'h11112222, 0);
        send_word(1, 32'h33334444, 0);
        do_start(1);
        send_word(2, 32'h55556666, 0);
        send_word(3, 32'h77778888, 0);
        wait_done("t4");
        drain("t4");
        check("t4_write_count", writes_total - w0, 4);
        check("t4_done_count", done_total - d0, 1);

        // Asynchronous reset mid-load, then a clean reload
        do_start(4);
        send_word(0, 32'hA1B2C3D4, 0);
        send_byte(8'h99, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t5_async");
        drain("t5_pre");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        w0 = writes_total;
        do_start(1);
        send_word(0, 32'h55AA33CC, 0);
        wait_done("t5");
        drain("t5");
        check("t5_write_count", writes_total - w0, 1);
        check("t5_mem0", mem_model[0], 32'h55AA33CC);

        // Full-depth load
        w0 = writes_total;
        do_start(1 << AW);
        for (int i = 0; i < (1 << AW); i++) begin
            send_word(AW'(i), (W'(i) * 32'h01000193) ^ 32'h5A5A0000, 0);
        end
        wait_done("t6");
        check("t6_last_addr", obs_addr[obs_addr.size()-1], (1 << AW) - 1);
        drain("t6");
        check("t6_write_count", writes_total - w0, 1 << AW);
        check("t6_done_latency", done_cyc, last_write_cyc + 1);
        check("t6_mem0", mem_model[0], 32'h5A5A0000);
        check("single_we_all", double_we, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
